upsizing: RTL and testbench

UPSIZING -- requirements
Module: upsizing

---
 rtl/upsizing.sv | 54 +++++
 tb/tb_upsizing.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/upsizing.sv
// upsizing: packs pairs of W-bit AXI-Stream words into one 2*W-bit word.
// The first (even) word of a pair lands in the upper half, the second (odd)
// word in the lower half. out_tvalid rises on the edge that accepts the odd word.
module upsizing #(
    parameter int W = 32
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic [W-1:0]   in_tdata,
    input  logic           in_tvalid,
    output logic           in_tready,
    output logic [2*W-1:0] out_tdata,
    output logic           out_tvalid,
    input  logic           out_tready
);

    logic [2*W-1:0] data;
    logic           lower_bits;
    logic           valid;
    logic           in_xfer;
    logic           out_xfer;

    // A held pair blocks the input until the sink takes it.
    assign in_tready  = ~valid | out_tready;
    assign in_xfer    = in_tvalid & in_tready;
    assign out_xfer   = valid & out_tready;
    assign out_tdata  = data;
    assign out_tvalid = valid;

    // Pair assembly: fill upper half, then lower half; completion raises valid,
    // an output transfer without a completing pair drops it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data       <= '0;
            lower_bits <= 1'b0;
            valid      <= 1'b0;
        end else begin
            if (in_xfer) begin
                if (!lower_bits) begin
                    data[2*W-1:W] <= in_tdata;
                    lower_bits    <= 1'b1;
                end else begin
                    data[W-1:0]   <= in_tdata;
                    lower_bits    <= 1'b0;
                end
            end
            if (in_xfer && lower_bits)
                valid <= 1'b1;
            else if (out_xfer)
                valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_upsizing.sv
// tb_upsizing: directed vector table plus streamed scoreboard runs for upsizing (W=40).
module tb_upsizing;

    localparam int W = 40;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [W-1:0]   in_tdata;
    logic           in_tvalid;
    logic           in_tready;
    logic [2*W-1:0] out_tdata;
    logic           out_tvalid;
    logic           out_tready;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] words [6];
    logic [W-1:0] q [$];

    typedef struct {
        logic           vld;
        logic [W-1:0]   d;
        logic           ordy;
        logic           exp_irdy;
        logic           exp_ov;
        logic [2*W-1:0] exp_od;
    } vec_t;

    vec_t tbl [16];

    upsizing #(.W(W)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vld, input logic [W-1:0] d, input logic ordy,
                                input logic irdy, input logic ov, input logic [2*W-1:0] od);
        vec_t v;
        v.vld = vld; v.d = d; v.ordy = ordy;
        v.exp_irdy = irdy; v.exp_ov = ov; v.exp_od = od;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge aclk);
        aresetn    = 1'b0;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        out_tready = 1'b1;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // Streams nwords (cycling the six words) under an out_tready pattern and
    // checks every output pair against the queue of accepted inputs.
    // mode: 0 ready, 1 gapped valid, 2 stall 8/8, 3 toggle from 1, 4 toggle from 0, 5 random
    task automatic run_stream(input int mode, input int nwords, input string tag);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic [2*W-1:0] held;
        logic acc, oxf, stall;
        q.delete();
        while ((sent < nwords || q.size() != 0 || out_tvalid) && cyc < 600) begin
            @(negedge aclk);
            case (mode)
                2:       out_tready = (cyc < 8) || (cyc >= 16);
                3:       out_tready = (cyc % 2) == 0;
                4:       out_tready = (cyc % 2) == 1;
                5:       out_tready = (cyc < 50) ? 1'($urandom_range(0, 1)) : 1'b1;
                default: out_tready = 1'b1;
            endcase
            if (sent < nwords) begin
                if (mode == 1)      in_tvalid = (cyc % 2) == 0;
                else if (mode == 5) in_tvalid = $urandom_range(0, 3) != 0;
                else                in_tvalid = 1'b1;
            end else begin
                in_tvalid = 1'b0;
            end
            in_tdata = in_tvalid ? words[sent % 6] : '0;
            #1;
            stall = out_tvalid & ~out_tready;
            if (mode == 1) chk({tag, "_irdy_high"}, 80'(in_tready), 80'(1));
            if (stall)     chk({tag, "_irdy_stall"}, 80'(in_tready), 80'(0));
            acc  = in_tvalid & in_tready;
            oxf  = out_tvalid & out_tready;
            held = out_tdata;
            @(posedge aclk);
            #1;
            if (oxf) begin
                if (q.size() < 2) begin
                    total++; bad++;
                    $display("FAIL %s_extra_output actual=%h required=none", tag, held);
                end else begin
                    chk({tag, "_pair"}, held, {q[0], q[1]});
                    void'(q.pop_front());
                    void'(q.pop_front());
                end
                got++;
            end
            if (acc) begin
                q.push_back(in_tdata);
                sent++;
            end
            if (stall) chk({tag, "_hold"}, {79'(0), out_tvalid} ^ 80'(out_tdata ^ held), 80'(1));
            cyc++;
        end
        chk({tag, "_timeout"}, 80'(cyc < 600), 80'(1));
        chk({tag, "_queue_empty"}, 80'(q.size()), 80'(0));
        chk({tag, "_pair_count"}, 80'(got), 80'(nwords / 2));
    endtask

    initial begin
        logic [W-1:0] A, B, C, D, E, F;
        words[0] = "ABCDE"; words[1] = "FGHIJ"; words[2] = "KLMON";
        words[3] = "PQRST"; words[4] = "UVWXY"; words[5] = "Zabcd";
        A = words[0]; B = words[1]; C = words[2];
        D = words[3]; E = words[4]; F = words[5];

        // Back-to-back latency, then stall corners.
        tbl[0]  = mk(1, A, 1, 1, 0, {A, 40'h0});
        tbl[1]  = mk(1, B, 1, 1, 1, {A, B});
        tbl[2]  = mk(1, C, 1, 1, 0, {C, B});
        tbl[3]  = mk(1, D, 1, 1, 1, {C, D});
        tbl[4]  = mk(1, E, 1, 1, 0, {E, D});
        tbl[5]  = mk(1, F, 1, 1, 1, {E, F});
        tbl[6]  = mk(0, '0, 1, 1, 0, {E, F});
        tbl[7]  = mk(1, A, 0, 1, 0, {A, F});
        tbl[8]  = mk(1, B, 0, 1, 1, {A, B});
        tbl[9]  = mk(1, C, 0, 0, 1, {A, B});
        tbl[10] = mk(1, C, 1, 1, 0, {C, B});
        tbl[11] = mk(1, D, 1, 1, 1, {C, D});
        tbl[12] = mk(1, E, 0, 0, 1, {C, D});
        tbl[13] = mk(1, E, 1, 1, 0, {E, D});
        tbl[14] = mk(1, F, 1, 1, 1, {E, F});
        tbl[15] = mk(1, A, 1, 1, 0, {A, F});

        aresetn = 1'b0; in_tvalid = 1'b0; in_tdata = '0; out_tready = 1'b0;
        #12;
        chk("reset_ovalid", 80'(out_tvalid), 80'(0));
        chk("reset_odata", out_tdata, 80'(0));
        chk("reset_irdy", 80'(in_tready), 80'(1));
        do_reset();

        for (int i = 0; i < 16; i++) begin
            @(negedge aclk);
            in_tvalid  = tbl[i].vld;
            in_tdata   = tbl[i].d;
            out_tready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_irdy", i), 80'(in_tready), 80'(tbl[i].exp_irdy));
            @(posedge aclk);
            #1;
            chk($sformatf("vec%0d_ovalid", i), 80'(out_tvalid), 80'(tbl[i].exp_ov));
            chk($sformatf("vec%0d_odata", i), out_tdata, tbl[i].exp_od);
        end

        do_reset(); run_stream(0, 6,  "b2b");
        do_reset(); run_stream(1, 6,  "gap");
        do_reset(); run_stream(2, 18, "stall");
        do_reset(); run_stream(3, 18, "tog1");
        do_reset(); run_stream(4, 18, "tog0");
        do_reset(); run_stream(5, 18, "rand");

        // Reset mid-pair discards the held upper word.
        do_reset();
        @(negedge aclk);
        in_tvalid = 1'b1; in_tdata = A; out_tready = 1'b1;
        @(negedge aclk);
        in_tvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        chk("rst_mid_ovalid", 80'(out_tvalid), 80'(0));
        chk("rst_mid_odata", out_tdata, 80'(0));
        chk("rst_mid_irdy", 80'(in_tready), 80'(1));
        @(negedge aclk);
        aresetn = 1'b1;
        in_tvalid = 1'b1; in_tdata = B;
        @(posedge aclk); #1;
        chk("rst_first_ovalid", 80'(out_tvalid), 80'(0));
        @(negedge aclk);
        in_tdata = C;
        @(posedge aclk); #1;
        chk("rst_pair_ovalid", 80'(out_tvalid), 80'(1));
        chk("rst_pair_odata", out_tdata, {B, C});
        @(negedge aclk);
        in_tvalid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
